psum_writeback: RTL and testbench
=================================

Name: psum_writeback

Overview:
- Receiving end of the PE_array psum_out valid/ready stream.
- Accepts one DATA_BITWIDTH psum per handshake and writes it to the selected GLB bank at base_addr + element index.
- Pulses o_done once the programmed element count has been committed.
- Sits between PE_array (o_psum_out_data/o_psum_out_valid) and the GLB write port (i_we/i_wa/i_wd/i_bank_sel). It takes the write-side duties away from TOP_ctrl.

Parameters:
DATA_BITWIDTH, 32, psum word width
BANK_NUM, 3, number of GLB banks
BANK_DEPTH, 512, words per bank
ADDR_W, clogb2(BANK_DEPTH-1) = 9, GLB address width
BSEL_W, clogb2(BANK_NUM-1) = 2, bank select width

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous active-high reset
i_start  input  1  single-cycle start pulse; sampled only in IDLE
i_bank_sel  input  BSEL_W  destination bank, latched on start
i_base_addr  input  ADDR_W  first write address, latched on start
i_num_elem  input  ADDR_W+1  words to write (0..BANK_DEPTH), latched on start
o_busy  output  1  high in RUN and FLUSH
o_done  output  1  one-cycle completion pulse
i_psum_out_valid  input  1  PE_array psum valid
i_psum_out_data  input  DATA_BITWIDTH  PE_array psum data
o_psum_out_ready  output  1  ready to PE_array
o_glb_bank_sel  output  BSEL_W  GLB bank select
o_glb_we  output  1  GLB write enable
o_glb_wa  output  ADDR_W  GLB write address
o_glb_wd  output  DATA_BITWIDTH  GLB write data

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE.
  - All outputs are 0.
  - Counters and latched config are cleared.
  - A partially completed transfer is abandoned, with no further writes and no o_done.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - o_psum_out_ready=0.
  - On i_start: latch bank/base/num_elem and clear cnt.
  - If num_elem==0, go to DONE. Otherwise go to RUN.
- RUN:
  - o_psum_out_ready=1 (combinational from state, not from valid).
  - A handshake (valid & ready) registers a write for the next edge: o_glb_we=1, o_glb_wa=(base+cnt) mod BANK_DEPTH, o_glb_wd=data. Then cnt++.
  - On the handshake where cnt==num_elem-1, go to FLUSH. Ready drops in FLUSH, so no extra beat is accepted.
  - No handshake gives o_glb_we=0 on the next cycle.
  - Back-to-back handshakes give one write per cycle (full throughput).
- FLUSH: one cycle while the final registered write is presented. Ready=0. Then go to DONE.
- DONE:
  - o_done=1 for exactly one cycle, o_busy=0, then go to IDLE.
  - o_done is never asserted before the last o_glb_we has been presented.
- Latency: handshake at edge N means o_glb_we is high during cycle N+1.
- Address wrap: the sum base+cnt is computed in ADDR_W+1 bits and truncated to ADDR_W, so base=510, num=4 gives 510, 511, 0, 1.
- i_start outside IDLE is ignored. Config inputs may change freely after the start pulse.
- Valid asserted in IDLE/FLUSH/DONE is not accepted (ready=0). Data must be held by the sender per valid/ready rules.
- o_glb_bank_sel drives the latched bank in all states and is 0 after reset.

Optional Feature:
PSUM_WB_RELU_EN:
- Defined: a write datum whose MSB is 1 (signed negative) is replaced by 0 before o_glb_wd. Non-negative values pass unchanged. Latency is unchanged.
- Undefined: data is written bit-exact. No ReLU logic is instantiated.

Test Plan:
- Reset then idle: i_rst=1 for 10 cycles, then 0 → all outputs 0, ready=0. Valid=1 with data 0x5 causes no GLB write.
- Basic burst: start bank=1 base=45 num=4; valid held high with data 0x10..0x13 → writes at 45..48 on 4 consecutive cycles, each one cycle after its handshake. o_done pulses 2 cycles after the last handshake. Exactly 4 handshakes occur.
- Gapped valid with wrap: base=510 num=3; valid toggles 1,0,1,0,1 with data 0xA, 0xB, 0xC → writes (510,0xA), (511,0xB), (0,0xC). o_glb_we is low in the gap cycles.
- Zero length: start num=0 → no ready, no write, o_done one cycle after start. A repeated i_start during RUN of a num=2 job is ignored.
- Reset mid-transfer: num=5, assert i_rst after 2 handshakes → outputs 0 immediately (asynchronous), no o_done. A new start base=0 num=1, data 0x7 → single write (0,0x7).
- ReLU: data 0xFFFFFFFE then 0x00000003 → with PSUM_WB_RELU_EN, writes 0x0 and 0x3. Without it, writes 0xFFFFFFFE and 0x3.

Source files
------------

// File: rtl/psum_writeback.sv
// psum_writeback: receiving end of the PE_array psum valid/ready stream.
// Each accepted psum is registered and written to the latched GLB bank at
// (base + element index) mod BANK_DEPTH, one write per cycle at full
// throughput. o_done pulses once the programmed element count has been
// presented on the GLB write port.
//
// Optional feature macro: PSUM_WB_RELU_EN
//   defined   : negative (MSB=1) write data is replaced by zero
//   undefined : data is written bit-exact
module psum_writeback #(
  parameter int DATA_BITWIDTH = 32,
  parameter int BANK_NUM      = 3,
  parameter int BANK_DEPTH    = 512,
  parameter int ADDR_W        = $clog2(BANK_DEPTH),
  parameter int BSEL_W        = $clog2(BANK_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [BSEL_W-1:0]        i_bank_sel,
  input  logic [ADDR_W-1:0]        i_base_addr,
  input  logic [ADDR_W:0]          i_num_elem,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic                     i_psum_out_valid,
  input  logic [DATA_BITWIDTH-1:0] i_psum_out_data,
  output logic                     o_psum_out_ready,
  output logic [BSEL_W-1:0]        o_glb_bank_sel,
  output logic                     o_glb_we,
  output logic [ADDR_W-1:0]        o_glb_wa,
  output logic [DATA_BITWIDTH-1:0] o_glb_wd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [BSEL_W-1:0]        bank_q, bank_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [ADDR_W:0]          num_q, num_d;
  logic [ADDR_W:0]          cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [ADDR_W-1:0]        wa_q, wa_d;
  logic [DATA_BITWIDTH-1:0] wd_q, wd_d;

  logic                     hs;
  logic                     last_beat;
  logic [ADDR_W:0]          addr_sum;
  logic [DATA_BITWIDTH-1:0] wr_data;

  // Ready depends only on state so the sender never sees a valid->ready loop.
  assign o_psum_out_ready = (state_q == S_RUN);
  assign o_busy           = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign o_done           = (state_q == S_DONE);
  assign o_glb_bank_sel   = bank_q;
  assign o_glb_we         = we_q;
  assign o_glb_wa         = wa_q;
  assign o_glb_wd         = wd_q;

  assign hs        = i_psum_out_valid && o_psum_out_ready;
  assign last_beat = (cnt_q == (num_q - CNT_ONE));
  // Sum carries one extra bit; dropping it gives the wrap at the bank end.
  assign addr_sum  = {1'b0, base_q} + cnt_q;

`ifdef PSUM_WB_RELU_EN
  assign wr_data = i_psum_out_data[DATA_BITWIDTH-1] ? '0 : i_psum_out_data;
`else
  assign wr_data = i_psum_out_data;
`endif

  // Next-state, config latch, beat counter and registered GLB write.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    bank_d  = bank_q;
    base_d  = base_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          bank_d  = i_bank_sel;
          base_d  = i_base_addr;
          num_d   = i_num_elem;
          cnt_d   = '0;
          state_d = (i_num_elem == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (hs) begin
          we_d  = 1'b1;
          wa_d  = addr_sum[ADDR_W-1:0];
          wd_d  = wr_data;
          cnt_d = cnt_q + CNT_ONE;
          if (last_beat) begin
            state_d = S_FLUSH;
          end
        end
      end
      // Final write is on the port this cycle; completion follows it.
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      base_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      bank_q  <= bank_d;
      base_q  <= base_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_psum_writeback.sv
// Self-checking bench for psum_writeback: reset/idle checks, a directed
// vector table, reset mid-transfer, then randomized jobs scored against a
// list model (address = (base+i) mod depth, data = optional ReLU of beat i,
// write one cycle after its handshake, done one cycle after the last write).
module tb_psum_writeback;

  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int BW    = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start;
  logic [BW-1:0] i_bank_sel;
  logic [AW-1:0] i_base_addr;
  logic [AW:0]   i_num_elem;
  logic          o_busy;
  logic          o_done;
  logic          i_psum_out_valid;
  logic [DW-1:0] i_psum_out_data;
  logic          o_psum_out_ready;
  logic [BW-1:0] o_glb_bank_sel;
  logic          o_glb_we;
  logic [AW-1:0] o_glb_wa;
  logic [DW-1:0] o_glb_wd;

  psum_writeback dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_start          (i_start),
    .i_bank_sel       (i_bank_sel),
    .i_base_addr      (i_base_addr),
    .i_num_elem       (i_num_elem),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .i_psum_out_valid (i_psum_out_valid),
    .i_psum_out_data  (i_psum_out_data),
    .o_psum_out_ready (o_psum_out_ready),
    .o_glb_bank_sel   (o_glb_bank_sel),
    .o_glb_we         (o_glb_we),
    .o_glb_wa         (o_glb_wa),
    .o_glb_wd         (o_glb_wd)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    int            edge_n;
    logic [BW-1:0] bank;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];

  // Monitor: every GLB write and done pulse, stamped with the edge count.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_glb_we) wr_q.push_back('{cyc, o_glb_bank_sel, o_glb_wa, o_glb_wd});
      if (o_done) done_q.push_back(cyc);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_wd(input logic [DW-1:0] d);
`ifdef PSUM_WB_RELU_EN
    if ($signed(d) < 0) return '0;
`endif
    return d;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " we"},    64'(o_glb_we), 64'(0));
    check({tag, " wa"},    64'(o_glb_wa), 64'(0));
    check({tag, " wd"},    64'(o_glb_wd), 64'(0));
    check({tag, " bank"},  64'(o_glb_bank_sel), 64'(0));
    check({tag, " ready"}, 64'(o_psum_out_ready), 64'(0));
    check({tag, " busy"},  64'(o_busy), 64'(0));
    check({tag, " done"},  64'(o_done), 64'(0));
  endtask

  // One complete job: start, stream beats with the given valid pattern,
  // wait for done, then score the recorded writes against the list model.
  task automatic run_job(input string tag, input int bank, input int base, input int num,
                         input logic [31:0] pat, input bit rand_valid, input bit restart,
                         input logic [DW-1:0] d0, input logic [DW-1:0] step,
                         output int done_delay, output int first_wa, output int last_wa,
                         output logic [DW-1:0] first_wd);
    logic [DW-1:0] dat[$];
    logic [DW-1:0] v;
    int  hs_edges[$];
    int  start_edge, idx, hs_cnt, k, budget, w0, dn0, nw, exp_dd;
    bit  hs_pend, done_seen, vld;

    v = d0;
    for (int i = 0; i < num; i++) begin
      dat.push_back(v);
      v = v + step;
    end
    w0 = wr_q.size();
    dn0 = done_q.size();
    done_delay = -1; first_wa = -1; last_wa = -1; first_wd = '0;

    @(negedge i_clk);
    i_start = 1'b1;
    i_bank_sel = BW'(bank);
    i_base_addr = AW'(base);
    i_num_elem = (AW+1)'(num);
    i_psum_out_valid = 1'b0;
    start_edge = cyc + 1;
    idx = 0; hs_cnt = 0; k = 0; hs_pend = 0; done_seen = 0;
    budget = num * 40 + 20;

    while (!done_seen && budget > 0) begin
      @(negedge i_clk);
      budget--;
      if (hs_pend) idx++;
      hs_pend = 0;
      if (k == 0) check({tag, " busy_after_start"}, 64'(o_busy), 64'(num != 0));
      check({tag, " ready_without_busy"}, 64'(o_psum_out_ready && !o_busy), 64'(0));
      if (o_done) begin
        done_seen = 1;
        check({tag, " busy_at_done"}, 64'(o_busy), 64'(0));
      end
      // Config inputs are free to change after the start pulse.
      i_start = restart && (k == 0);
      i_bank_sel = BW'($urandom);
      i_base_addr = AW'($urandom);
      i_num_elem = (AW+1)'($urandom);
      vld = rand_valid ? 1'($urandom_range(0, 1)) : ((k < 32) ? pat[k] : 1'b1);
      i_psum_out_valid = vld;
      i_psum_out_data = (idx < num) ? dat[idx] : DW'($urandom);
      hs_pend = vld && o_psum_out_ready;
      if (hs_pend) begin
        hs_cnt++;
        hs_edges.push_back(cyc + 1);
      end
      k++;
    end
    if (!done_seen) check({tag, " done_timeout"}, 64'(0), 64'(1));

    // Valid held high after completion must not be accepted.
    i_start = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      i_psum_out_valid = 1'b1;
      i_psum_out_data = DW'($urandom);
      if (o_psum_out_ready) hs_cnt++;
    end
    @(negedge i_clk);
    i_psum_out_valid = 1'b0;
    @(negedge i_clk);

    nw = wr_q.size() - w0;
    check({tag, " handshakes"}, 64'(hs_cnt), 64'(num));
    check({tag, " writes"}, 64'(nw), 64'(num));
    for (int i = 0; i < num && i < nw; i++) begin
      wr_t w;
      w = wr_q[w0 + i];
      check($sformatf("%s bank[%0d]", tag, i), 64'(w.bank), 64'(bank));
      check($sformatf("%s addr[%0d]", tag, i), 64'(w.wa), 64'((base + i) % DEPTH));
      check($sformatf("%s data[%0d]", tag, i), 64'(w.wd), 64'(model_wd(dat[i])));
      if (i < hs_edges.size())
        check($sformatf("%s latency[%0d]", tag, i), 64'(w.edge_n), 64'(hs_edges[i]));
    end
    if (nw > 0) begin
      first_wa = int'(wr_q[w0].wa);
      last_wa = int'(wr_q[w0 + nw - 1].wa);
      first_wd = wr_q[w0].wd;
    end
    check({tag, " done_count"}, 64'(done_q.size() - dn0), 64'(1));
    if (done_q.size() > dn0) begin
      done_delay = done_q[dn0] - start_edge;
      exp_dd = (hs_edges.size() == 0) ? 0 : hs_edges[hs_edges.size() - 1] + 1 - start_edge;
      check({tag, " done_timing"}, 64'(done_delay), 64'(exp_dd));
    end
  endtask

  typedef struct {
    int            bank;
    int            base;
    int            num;
    logic [31:0]   pat;
    bit            restart;
    logic [DW-1:0] d0;
    logic [DW-1:0] step;
    int            exp_done_delay;
    int            exp_first_wa;
    int            exp_last_wa;
    logic [DW-1:0] exp_first_wd;
  } vec_t;

  initial begin
    vec_t          vecs[$];
    logic [DW-1:0] relu_first;
    int            dd, fwa, lwa, w0, dn0;
    logic [DW-1:0] fwd;

`ifdef PSUM_WB_RELU_EN
    relu_first = 32'h0000_0000;
`else
    relu_first = 32'hFFFF_FFFE;
`endif
    // bank, base, num, valid pattern, restart, d0, step, done delay, first wa, last wa, first wd
    vecs.push_back('{1,  45,   4, 32'hFFFF_FFFF, 1'b0, 32'h10,        32'h1, 5,   45,  48,  32'h10});
    vecs.push_back('{2, 510,   3, 32'h0000_0015, 1'b0, 32'hA,         32'h1, 6,   510, 0,   32'hA});
    vecs.push_back('{0,   7,   0, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'h0, 0,   -1,  -1,  32'h0});
    vecs.push_back('{1,  20,   2, 32'hFFFF_FFFF, 1'b1, 32'h21,        32'h1, 3,   20,  21,  32'h21});
    vecs.push_back('{0, 100,   2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h5, 3,   100, 101, relu_first});
    vecs.push_back('{2, 511,   1, 32'h0000_0004, 1'b0, 32'hDEAD,      32'h0, 4,   511, 511, 32'hDEAD});
    vecs.push_back('{2, 300, 512, 32'hFFFF_FFFF, 1'b0, 32'h1000,      32'h3, 513, 300, 299, 32'h1000});

    i_start = 1'b0;
    i_bank_sel = '0;
    i_base_addr = '0;
    i_num_elem = '0;
    i_psum_out_valid = 1'b0;
    i_psum_out_data = '0;
    i_rst = 1'b1;

    // Reset, then idle with valid asserted: nothing may be accepted.
    repeat (10) @(negedge i_clk);
    check_all_zero("in_reset");
    i_rst = 1'b0;
    @(negedge i_clk);
    check_all_zero("after_reset");
    w0 = wr_q.size();
    i_psum_out_valid = 1'b1;
    i_psum_out_data = 32'h5;
    repeat (3) begin
      @(negedge i_clk);
      check("idle_ready", 64'(o_psum_out_ready), 64'(0));
    end
    i_psum_out_valid = 1'b0;
    @(negedge i_clk);
    check("idle_no_write", 64'(wr_q.size() - w0), 64'(0));

    // Directed vector table.
    for (int t = 0; t < vecs.size(); t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      run_job(tag, vecs[t].bank, vecs[t].base, vecs[t].num, vecs[t].pat, 1'b0,
              vecs[t].restart, vecs[t].d0, vecs[t].step, dd, fwa, lwa, fwd);
      check({tag, " done_delay"}, 64'(dd), 64'(vecs[t].exp_done_delay));
      if (vecs[t].num > 0) begin
        check({tag, " first_wa"}, 64'(fwa), 64'(vecs[t].exp_first_wa));
        check({tag, " last_wa"},  64'(lwa), 64'(vecs[t].exp_last_wa));
        check({tag, " first_wd"}, 64'(fwd), 64'(vecs[t].exp_first_wd));
      end
    end

    // Reset mid-transfer: two beats written, then abandoned with no done.
    w0 = wr_q.size();
    dn0 = done_q.size();
    @(negedge i_clk);
    i_start = 1'b1;
    i_bank_sel = 2'd2;
    i_base_addr = 9'd200;
    i_num_elem = 10'd5;
    @(negedge i_clk);
    i_start = 1'b0;
    i_psum_out_valid = 1'b1;
    i_psum_out_data = 32'h100;
    @(negedge i_clk);
    i_psum_out_data = 32'h101;
    @(negedge i_clk);
    i_psum_out_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (8) @(negedge i_clk);
    check("abort_writes", 64'(wr_q.size() - w0), 64'(2));
    check("abort_no_done", 64'(done_q.size() - dn0), 64'(0));
    if (wr_q.size() - w0 >= 2) begin
      check("abort_wa1", 64'(wr_q[w0 + 1].wa), 64'(201));
      check("abort_wd1", 64'(wr_q[w0 + 1].wd), 64'(model_wd(32'h101)));
    end
    run_job("post_abort", 0, 0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7, 32'h0, dd, fwa, lwa, fwd);
    check("post_abort wa", 64'(fwa), 64'(0));
    check("post_abort wd", 64'(fwd), 64'(32'h7));

    // Randomized jobs against the list model.
    for (int j = 0; j < 25; j++) begin
      int rn;
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 24));
      run_job($sformatf("rnd%0d", j), int'($urandom_range(0, 2)), int'($urandom_range(0, DEPTH - 1)),
              rn, 32'h0, 1'b1, 1'b0, DW'($urandom), DW'($urandom), dd, fwa, lwa, fwd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
